// File: rtl/kamikaze_shift_seq_pkg.sv
// Shared types for the iterative shift sequencer: shift function codes,
// sequencer states, step sizes and a small decode helper.
package kamikaze_shift_seq_pkg;

  localparam int XLEN_DEF = 32;
  localparam int SHW_DEF  = 5;

  typedef enum logic [1:0] {
    SHF_SLL  = 2'b00,
    SHF_SRL  = 2'b01,
    SHF_RSVD = 2'b10,
    SHF_SRA  = 2'b11
  } shf_func_t;

  typedef enum logic [1:0] {
    SHS_IDLE  = 2'b00,
    SHS_SHIFT = 2'b01,
    SHS_DONE  = 2'b10
  } shs_state_t;

  localparam logic [2:0] STEP_ONE  = 3'd1;
  localparam logic [2:0] STEP_FAST = 3'd4;

  // Ops that need no iteration complete straight from the accept edge.
  function automatic logic skips_shift(input shf_func_t f, input logic shamt_zero);
    return (f == SHF_RSVD) || shamt_zero;
  endfunction

endpackage

// File: rtl/kamikaze_shift_step.sv
// One combinational shift step of 1 or 4 bit positions for SLL/SRL/SRA.
// SRA fills vacated bits with the sign latched at accept, not the current MSB.
module kamikaze_shift_step
  import kamikaze_shift_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] data,
  input  shf_func_t       func,
  input  logic            sign,
  input  logic [2:0]      amount,
  output logic [XLEN-1:0] next_data
);

  logic [XLEN-1:0] fill_mask;

  always_comb begin
    fill_mask = ~({XLEN{1'b1}} >> amount);
    next_data = data;
    case (func)
      SHF_SLL: next_data = data << amount;
      SHF_SRL: next_data = data >> amount;
      SHF_SRA: next_data = (data >> amount) | (sign ? fill_mask : '0);
      default: next_data = data;
    endcase
  end

endmodule

// File: rtl/kamikaze_shift_seq.sv
// Iterative SLL/SRL/SRA sequencer: valid/ready in, valid/ready out, stall_o while busy,
// latency shamt edges (1/cycle) or shamt/4+shamt%4 with KAMIKAZE_SHIFT_FAST_EN; flush wins.
module kamikaze_shift_seq
  import kamikaze_shift_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int SHW  = SHW_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      func_i,
  input  logic [XLEN-1:0] op_i,
  input  logic [SHW-1:0]  shamt_i,
  input  logic [4:0]      rf_rd_i,
  input  logic            rf_rd_we_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rf_rd_o,
  output logic            rf_rd_we_o
);

  shs_state_t      state;
  shf_func_t       func;
  logic [XLEN-1:0] data;
  logic [SHW-1:0]  cnt;
  logic            sign;
  logic [4:0]      rd;
  logic            we;

  logic [2:0]      step_amt;
  logic [SHW-1:0]  step_cnt;
  logic [XLEN-1:0] next_data;

`ifdef KAMIKAZE_SHIFT_FAST_EN
  assign step_amt = (cnt >= SHW'(4)) ? STEP_FAST : STEP_ONE;
`else
  assign step_amt = STEP_ONE;
`endif
  assign step_cnt = SHW'(step_amt);

  kamikaze_shift_step #(.XLEN(XLEN)) u_step (
    .data      (data),
    .func      (func),
    .sign      (sign),
    .amount    (step_amt),
    .next_data (next_data)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= SHS_IDLE;
      func  <= SHF_SLL;
      data  <= '0;
      cnt   <= '0;
      sign  <= 1'b0;
      rd    <= '0;
      we    <= 1'b0;
    end else if (flush_i) begin
      // Abort drops any in-flight or pending result; only the write enable matters.
      state <= SHS_IDLE;
      we    <= 1'b0;
    end else begin
      case (state)
        SHS_IDLE: begin
          if (in_valid_i) begin
            data  <= op_i;
            cnt   <= shamt_i;
            func  <= shf_func_t'(func_i);
            sign  <= op_i[XLEN-1];
            rd    <= rf_rd_i;
            we    <= rf_rd_we_i;
            state <= skips_shift(shf_func_t'(func_i), shamt_i == '0) ? SHS_DONE : SHS_SHIFT;
          end
        end
        SHS_SHIFT: begin
          data <= next_data;
          cnt  <= cnt - step_cnt;
          if (cnt == step_cnt) begin
            state <= SHS_DONE;
          end
        end
        SHS_DONE: begin
          if (out_ready_i) begin
            state <= SHS_IDLE;
          end
        end
        default: state <= SHS_IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state == SHS_IDLE);
  assign stall_o     = (state != SHS_IDLE);
  assign out_valid_o = (state == SHS_DONE);
  assign result_o    = data;
  assign rf_rd_o     = rd;
  assign rf_rd_we_o  = we;

endmodule

// File: doc/kamikaze_shift_seq.md
Name: kamikaze_shift_seq

Overview:
- Iterative shift sequencer beside the execute-stage ALU. Implements SLL/SRL/SRA, which the single-cycle ALU does not support.
- Accepts one shift op from decode through a valid/ready handshake and shifts one bit per cycle. Holds `stall_o` so the pipeline freezes.
- Presents the result plus rd/we tags to writeback through a second valid/ready handshake.

Parameters:
- XLEN, 32, datapath width.
- SHW, 5, shift-amount width; must equal log2(XLEN).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  decode presents a shift op.
- in_ready_o  out  1  sequencer can accept; equals (state==IDLE).
- func_i  in  2  00 SLL, 01 SRL, 11 SRA, 10 reserved.
- op_i  in  XLEN  operand to shift.
- shamt_i  in  SHW  shift amount.
- rf_rd_i  in  5  destination register tag.
- rf_rd_we_i  in  1  destination write enable.
- flush_i  in  1  synchronous abort from branch/exception.
- stall_o  out  1  pipeline hold; equals (state!=IDLE).
- out_valid_o  out  1  result available; equals (state==DONE).
- out_ready_i  in  1  writeback consumes the result.
- result_o  out  XLEN  shifted value.
- rf_rd_o  out  5  registered rd tag.
- rf_rd_we_o  out  1  registered write enable.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state=IDLE; data, cnt, rd and we registers all 0.
  - Hence result_o=0, rf_rd_o=0, rf_rd_we_o=0, out_valid_o=0, stall_o=0, in_ready_o=1.
- Accept: occurs when in_valid_i && in_ready_o && !flush_i at edge E0.
  - Latch data<=op_i, cnt<=shamt_i, func, sign<=op_i[XLEN-1], rd and we.
  - Reserved func 10, or shamt_i==0: go straight to DONE with data=op_i.
  - Otherwise go to SHIFT.
- SHIFT, each edge:
  - SLL: data<=data<<1.
  - SRL: data<=data>>1, zero fill.
  - SRA: data<=data>>1, filled with the latched sign bit.
  - cnt<=cnt-1; when cnt==1 at the edge, go to DONE.
  - Latency: out_valid_o rises after edge E0+k for k=shamt>0, after E0 for k=0. Example: shamt=31 gives 31 cycles.
- DONE:
  - result_o, rf_rd_o, rf_rd_we_o are held stable while out_ready_i=0.
  - An edge with out_ready_i=1 returns to IDLE; out_valid_o drops.
  - No new op is accepted in the same cycle (in_ready_o=0 in DONE).
- Flush:
  - flush_i=1 at any edge forces IDLE and clears rf_rd_we_o; data content is don't-care.
  - Flush beats accept, shift step and output handshake in the same cycle.
  - A result in DONE with flush_i=1 is discarded even if out_ready_i=1.
- in_valid_i while busy is ignored; decode must hold it because stall_o=1.
- Reset asserted mid-operation: immediate return to reset values; no partial result is emitted.
- Width: shifts are logical on XLEN bits, shamt is unsigned; no overflow flags.

Optional Feature:
- Macro KAMIKAZE_SHIFT_FAST_EN.
- Defined: in SHIFT, when cnt>=4, shift by 4 and cnt<=cnt-4; otherwise shift by 1.
  - Latency k/4 + k%4, with integer division. Example: shamt=31 gives 10 cycles; shamt=8 gives 2.
  - Transition to DONE occurs when the step brings cnt to 0.
- Undefined: one bit per cycle as above. All handshake, flush and reset rules are unchanged.

Decomposition:
- Shared package riscv_defines.v gains:
  - `SHF_SLL 2'b00, `SHF_SRL 2'b01, `SHF_SRA 2'b11.
  - State codes `SHS_IDLE, `SHS_SHIFT, `SHS_DONE.
- One combinational sub-module, kamikaze_shift_step.
  - Inputs: data, func, sign, amount (1 or 4).
  - Output: next data.
  - Instantiated once; the step select is driven by the FAST macro.

Test Plan:
- Reset then SLL, op=0x00000001, shamt=4: in_ready_o=0 for 4 cycles; out_valid_o after edge E0+4 with result_o=0x00000010, rf_rd_o=rd tag.
- SRA, op=0x80000000, shamt=31: result_o=0xFFFFFFFF after 31 cycles (10 with FAST); SRL on the same op gives 0x00000001.
- shamt=0 SRL, op=0xDEADBEEF: out_valid_o one edge after accept with result_o=0xDEADBEEF; hold out_ready_i=0 for 5 cycles and the result stays stable; out_ready_i=1 returns to IDLE next edge.
- SLL shamt=10; assert flush_i at cycle 3: next edge state=IDLE, out_valid_o=0, rf_rd_we_o=0, stall_o=0; a new op is accepted the following cycle.
- flush_i and in_valid_i together in IDLE: not accepted, stall_o stays 0. flush_i with out_ready_i in DONE: result dropped, no writeback.
- Async reset pulse mid-SHIFT, between clock edges: outputs go to reset values immediately; in_ready_o=1 after release.
